uart_fifo_ctrl: RTL and testbench

Pointer and status controller for the UART FIFOs (TX and RX). It accepts push/pop requests from the UART datapath and drives the write enable and write/read addresses of the FIFO's register-file storage, which has a combinational read port. It also produces full, empty, occupancy, almost-full/almost-empty and sticky overflow/underflow status. Reads are first-word-fall-through: the storage read data is valid whenever `empty` is low.

---
 rtl/uart_fifo_pkg.sv | 7 +
 rtl/uart_fifo_ptr.sv | 33 +++
 rtl/uart_fifo_ctrl.sv | 92 +++++++++
 tb/tb_uart_fifo_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared UART FIFO constants: default storage geometry used by the FIFO top, its controller and the bench.
package uart_fifo_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_BITS  = 9;

endpackage : uart_fifo_pkg

// File: rtl/uart_fifo_ptr.sv
// Wrapping FIFO pointer with an extra wrap bit; advances one edge after inc, async reset to zero.
// No backpressure of its own: the controller only asserts inc for accepted operations.
module uart_fifo_ptr #(
    parameter int addr_width = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    output logic [addr_width:0] ptr
);

    logic [addr_width:0] ptr_q;
    logic [addr_width:0] ptr_d;

    // Natural binary wrap of the extra MSB is what keeps full/empty distinguishable.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + {{addr_width{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : uart_fifo_ptr

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO pointer/status controller: w_en is combinational in the request cycle, status updates one edge later.
// A push while full without a pop is dropped (overflow); a pop while empty is ignored (underflow).
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH,
    parameter int AF_LEVEL   = 2**addr_width - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [addr_width-1:0] w_addr,
    output logic [addr_width-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = addr_width + 1;
    localparam logic [CW-1:0] AF_LVL = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL = CW'(AE_LEVEL);

    logic [CW-1:0] w_ptr;
    logic [CW-1:0] r_ptr;
    logic          wr_ok;
    logic          rd_ok;
    logic          ovf_set;
    logic          unf_set;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;

    uart_fifo_ptr #(.addr_width(addr_width)) u_w_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_ok),
        .ptr     (w_ptr)
    );

    uart_fifo_ptr #(.addr_width(addr_width)) u_r_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_ok),
        .ptr     (r_ptr)
    );

    // A pop frees the slot in the same edge, so a push alongside it is accepted even when full.
    always_comb begin
        wr_ok       = wr & (~full | rd);
        rd_ok       = rd & ~empty;
        ovf_set     = wr & full & ~rd;
        unf_set     = rd & empty;
        overflow_d  = ovf_set | (overflow_q & ~clr_err);
        underflow_d = unf_set | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Gate with reset so storage is never written while the pointers are held.
    assign w_en = wr_ok & reset_n;

    always_comb begin
        w_addr       = w_ptr[addr_width-1:0];
        r_addr       = r_ptr[addr_width-1:0];
        empty        = (w_ptr == r_ptr);
        full         = (w_ptr[addr_width] != r_ptr[addr_width]) &&
                       (w_ptr[addr_width-1:0] == r_ptr[addr_width-1:0]);
        count        = w_ptr - r_ptr;
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule : uart_fifo_ctrl

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: stimulus pushes expected outputs per cycle, a negedge monitor compares.
module tb_uart_fifo_ctrl;
    import uart_fifo_pkg::*;

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr;
    logic          rd;
    logic          clr_err;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    uart_fifo_ctrl #(.addr_width(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit w_en;
        int w_addr;
        int r_addr;
        bit full;
        bit empty;
        bit af;
        bit ae;
        int count;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   id_ctr = 0;

    // Reference occupancy model: free-running pointers modulo 2*DEPTH.
    int mw = 0;
    int mr = 0;
    bit movf = 0;
    bit munf = 0;

    function automatic exp_t expect_now(bit w, bit r, bit in_reset);
        exp_t e;
        int   cnt;
        cnt      = (mw - mr + PMOD) % PMOD;
        e.id     = id_ctr;
        e.count  = cnt;
        e.full   = (cnt == DEPTH);
        e.empty  = (cnt == 0);
        e.af     = (cnt >= DEPTH - 2);
        e.ae     = (cnt <= 2);
        e.w_addr = mw % DEPTH;
        e.r_addr = mr % DEPTH;
        e.ovf    = movf;
        e.unf    = munf;
        e.w_en   = !in_reset && w && (cnt != DEPTH || r);
        return e;
    endfunction

    task automatic step(input bit w, input bit r, input bit c);
        exp_t e;
        int   cnt;
        wr = w;
        rd = r;
        clr_err = c;
        e = expect_now(w, r, 1'b0);
        id_ctr++;
        sb.push_back(e);
        cnt = (mw - mr + PMOD) % PMOD;
        if (w && (cnt != DEPTH || r)) mw = (mw + 1) % PMOD;
        if (r && cnt != 0)            mr = (mr + 1) % PMOD;
        movf = (w && cnt == DEPTH && !r) || (movf && !c);
        munf = (r && cnt == 0) || (munf && !c);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from any clock edge with a push pending; the monitor samples before the next edge.
    task automatic async_reset();
        #1;
        reset_n = 1'b0;
        wr = 1'b1;
        rd = 1'b1;
        clr_err = 1'b0;
        mw = 0;
        mr = 0;
        movf = 0;
        munf = 0;
        sb.push_back(expect_now(1'b1, 1'b1, 1'b1));
        id_ctr++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            tests++;
            if (w_en !== mon_e.w_en || int'(w_addr) != mon_e.w_addr ||
                int'(r_addr) != mon_e.r_addr || full !== mon_e.full ||
                empty !== mon_e.empty || almost_full !== mon_e.af ||
                almost_empty !== mon_e.ae || int'(count) != mon_e.count ||
                overflow !== mon_e.ovf || underflow !== mon_e.unf) begin
                fails++;
                $display("FAIL rec%0d got: w_en=%0b wa=%0d ra=%0d full=%0b empty=%0b af=%0b ae=%0b cnt=%0d ovf=%0b unf=%0b | need: w_en=%0b wa=%0d ra=%0d full=%0b empty=%0b af=%0b ae=%0b cnt=%0d ovf=%0b unf=%0b",
                         mon_e.id, w_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
                         count, overflow, underflow, mon_e.w_en, mon_e.w_addr, mon_e.r_addr,
                         mon_e.full, mon_e.empty, mon_e.af, mon_e.ae, mon_e.count, mon_e.ovf, mon_e.unf);
            end
        end
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        clr_err = 1'b0;
        @(posedge clk);
        #1;
        async_reset();

        // Pop while empty after reset, then clear.
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Fill to DEPTH, then overflow and sticky-flag handling.
        repeat (DEPTH) step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Simultaneous push/pop while full keeps count at DEPTH.
        repeat (3) step(1, 1, 0);
        step(0, 0, 0);

        // Drain, then underflow and push+pop while empty.
        repeat (DEPTH) step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);

        // Single-word push/pop pairs across the address wrap.
        repeat (40) begin
            step(1, 0, 0);
            step(0, 1, 0);
        end
        step(0, 0, 0);

        // Async reset at count 17, then the next push lands at address 0.
        repeat (17) step(1, 0, 0);
        async_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_fifo_ctrl
